// File: rtl/tdm_demux4_pkg.sv
// Shared types and constants for the TDM 1:4 demultiplexer.
// Slot indexing, alignment-state encoding and the one-hot channel strobe helper.
package tdm_demux4_pkg;

  localparam int NSLOT  = 4;
  localparam int SLOT_W = $clog2(NSLOT);
  localparam int MISS_W = 3;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  function automatic logic [NSLOT-1:0] slot_onehot(input logic [SLOT_W-1:0] s);
    slot_onehot = NSLOT'(1) << s;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot position counter for the demux: wraps modulo NSLOT.
// Clear has priority over load-to-1, which has priority over increment.
module tdm_slot_ctr
  import tdm_demux4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load1,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot
);

  logic [SLOT_W-1:0] slot_d, slot_q;

  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      slot_d = '0;
    end else if (load1) begin
      slot_d = SLOT_W'(1);
    end else if (inc) begin
      slot_d = slot_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;

endmodule

// File: rtl/tdm_demux4.sv
// Receive-side TDM 1:4 demultiplexer with frame assembly and hunt/lock alignment.
// The slot-0 beat carries fsync; missing syncs are flywheeled up to MISS_LIMIT-1 times.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int W          = 1,
  parameter int MISS_LIMIT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [W-1:0]       din,
  input  logic               din_vld,
  input  logic               fsync,
  output logic [NSLOT*W-1:0] ch_data,
  output logic [NSLOT-1:0]   ch_strobe,
  output logic [NSLOT*W-1:0] frame_data,
  output logic               frame_valid,
  output logic               locked,
  output logic               sync_err
);

  localparam logic [MISS_W-1:0] MISS_LIM_V = MISS_W'(MISS_LIMIT);
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(NSLOT - 1);

  state_e state_d, state_q;
  logic [MISS_W-1:0] miss_d, miss_q, miss_inc;

  logic [(NSLOT-1)*W-1:0] shadow_d, shadow_q;
  logic [NSLOT*W-1:0]     ch_data_d, ch_data_q;
  logic [NSLOT*W-1:0]     frame_data_d, frame_data_q;
  logic [NSLOT-1:0]       ch_strobe_d, ch_strobe_q;
  logic                   frame_valid_d, frame_valid_q;
  logic                   sync_err_d, sync_err_q;

  logic              slot_clr, slot_load1, slot_inc;
  logic [SLOT_W-1:0] slot;
  logic              accept;
  logic [SLOT_W-1:0] acc_slot;

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (slot_clr),
    .load1 (slot_load1),
    .inc   (slot_inc),
    .slot  (slot)
  );

  // Alignment control: decides whether this beat is accepted and at which slot.
  always_comb begin
    state_d    = state_q;
    miss_d     = miss_q;
    miss_inc   = miss_q + MISS_W'(1);
    sync_err_d = 1'b0;
    accept     = 1'b0;
    acc_slot   = slot;
    slot_clr   = 1'b0;
    slot_load1 = 1'b0;
    slot_inc   = 1'b0;
    if (din_vld) begin
      unique case (state_q)
        ST_HUNT: begin
          if (fsync) begin
            state_d    = ST_LOCKED;
            miss_d     = '0;
            accept     = 1'b1;
            acc_slot   = '0;
            slot_load1 = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (slot == '0) begin
            if (fsync) begin
              miss_d   = '0;
              accept   = 1'b1;
              slot_inc = 1'b1;
            end else begin
              sync_err_d = 1'b1;
              if (miss_inc >= MISS_LIM_V) begin
                state_d  = ST_HUNT;
                miss_d   = '0;
                slot_clr = 1'b1;
              end else begin
                miss_d   = miss_inc;
                accept   = 1'b1;
                slot_inc = 1'b1;
              end
            end
          end else if (fsync) begin
            // Early sync restarts the frame here; the partial frame never completes.
            sync_err_d = 1'b1;
            miss_d     = '0;
            accept     = 1'b1;
            acc_slot   = '0;
            slot_load1 = 1'b1;
          end else begin
            accept   = 1'b1;
            slot_inc = 1'b1;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // Steering and frame assembly for an accepted beat.
  always_comb begin
    ch_data_d     = ch_data_q;
    ch_strobe_d   = '0;
    shadow_d      = shadow_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    if (accept) begin
      ch_strobe_d = slot_onehot(acc_slot);
      for (int k = 0; k < NSLOT; k++) begin
        if (acc_slot == SLOT_W'(k)) begin
          ch_data_d[k*W +: W] = din;
        end
      end
      for (int k = 0; k < NSLOT - 1; k++) begin
        if (acc_slot == SLOT_W'(k)) begin
          shadow_d[k*W +: W] = din;
        end
      end
      if (acc_slot == LAST_SLOT) begin
        frame_data_d  = {din, shadow_q};
        frame_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_HUNT;
      miss_q        <= '0;
      shadow_q      <= '0;
      ch_data_q     <= '0;
      ch_strobe_q   <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      miss_q        <= miss_d;
      shadow_q      <= shadow_d;
      ch_data_q     <= ch_data_d;
      ch_strobe_q   <= ch_strobe_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign ch_data     = ch_data_q;
  assign ch_strobe   = ch_strobe_q;
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed vector table, async reset sequence,
// and randomized traffic checked against a queue-based frame model.
module tb_tdm_demux4;

  localparam int W  = 1;
  localparam int ML = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   din;
  logic           din_vld;
  logic           fsync;
  logic [4*W-1:0] ch_data;
  logic [3:0]     ch_strobe;
  logic [4*W-1:0] frame_data;
  logic           frame_valid;
  logic           locked;
  logic           sync_err;

  tdm_demux4 #(.W(W), .MISS_LIMIT(ML)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_vld     (din_vld),
    .fsync       (fsync),
    .ch_data     (ch_data),
    .ch_strobe   (ch_strobe),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  typedef struct {
    logic           v;
    logic           fs;
    logic [W-1:0]   d;
    logic [3:0]     stb;
    logic           fv;
    logic [4*W-1:0] fd;
    logic           lk;
    logic           err;
    logic [4*W-1:0] chd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic fs, input logic d, input logic [3:0] stb,
                              input logic fv, input logic [3:0] fd, input logic lk, input logic err,
                              input logic [3:0] chd);
    vec_t e;
    e.v = v; e.fs = fs; e.d = d; e.stb = stb; e.fv = fv;
    e.fd = fd; e.lk = lk; e.err = err; e.chd = chd;
    tbl.push_back(e);
  endfunction

  task automatic drive(input logic v, input logic fs, input logic [W-1:0] d);
    @(negedge clk);
    din_vld = v;
    fsync   = fs;
    din     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ch_data"},     32'(ch_data),     32'd0);
    chk({tag, "_ch_strobe"},   32'(ch_strobe),   32'd0);
    chk({tag, "_frame_data"},  32'(frame_data),  32'd0);
    chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
    chk({tag, "_locked"},      32'(locked),      32'd0);
    chk({tag, "_sync_err"},    32'(sync_err),    32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    din_vld = 1'b0; fsync = 1'b0; din = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: accepted beats of the current alignment collect in a queue.
  logic           m_lock;
  int             m_slot;
  int             m_miss;
  logic [W-1:0]   m_frame[$];
  logic [4*W-1:0] m_chd, m_fd;
  logic [3:0]     m_stb;
  logic           m_fv, m_err;

  function automatic void m_reset();
    m_lock = 1'b0; m_slot = 0; m_miss = 0; m_frame.delete();
    m_chd = '0; m_fd = '0; m_stb = '0; m_fv = 1'b0; m_err = 1'b0;
  endfunction

  function automatic void m_accept(input logic [W-1:0] d);
    m_chd[m_slot*W +: W] = d;
    m_stb = 4'(1 << m_slot);
    m_frame.push_back(d);
    if (m_frame.size() == 4) begin
      for (int k = 0; k < 4; k++) m_fd[k*W +: W] = m_frame[k];
      m_fv = 1'b1;
      m_frame.delete();
    end
    m_slot = (m_slot + 1) % 4;
  endfunction

  function automatic void m_step(input logic v, input logic fs, input logic [W-1:0] d);
    m_stb = '0; m_fv = 1'b0; m_err = 1'b0;
    if (!v) return;
    if (!m_lock) begin
      if (fs) begin
        m_lock = 1'b1; m_miss = 0; m_slot = 0; m_frame.delete();
        m_accept(d);
      end
    end else if (m_slot == 0) begin
      if (fs) begin
        m_miss = 0;
        m_accept(d);
      end else begin
        m_err = 1'b1;
        m_miss++;
        if (m_miss >= ML) begin
          m_lock = 1'b0; m_miss = 0; m_frame.delete();
        end else begin
          m_accept(d);
        end
      end
    end else if (fs) begin
      m_err = 1'b1; m_miss = 0; m_slot = 0; m_frame.delete();
      m_accept(d);
    end else begin
      m_accept(d);
    end
  endfunction

  initial begin
    int gen_slot;
    logic v, fs;
    logic [W-1:0] d;

    rst_n = 1'b0; din_vld = 1'b0; fsync = 1'b0; din = '0;

    //   v  fs d  stb      fv fd       lk err chd
    add(1, 1, 0, 4'b0001, 0, 4'b0000, 1, 0, 4'b0000);
    add(1, 0, 1, 4'b0010, 0, 4'b0000, 1, 0, 4'b0010);
    add(1, 0, 0, 4'b0100, 0, 4'b0000, 1, 0, 4'b0010);
    add(1, 0, 1, 4'b1000, 1, 4'b1010, 1, 0, 4'b1010);
    add(0, 0, 0, 4'b0000, 0, 4'b1010, 1, 0, 4'b1010);
    add(1, 0, 1, 4'b0001, 0, 4'b1010, 1, 1, 4'b1011);
    add(1, 0, 0, 4'b0010, 0, 4'b1010, 1, 0, 4'b1001);
    add(1, 0, 0, 4'b0100, 0, 4'b1010, 1, 0, 4'b1001);
    add(1, 0, 0, 4'b1000, 1, 4'b0001, 1, 0, 4'b0001);
    add(1, 0, 1, 4'b0000, 0, 4'b0001, 0, 1, 4'b0001);
    add(1, 0, 1, 4'b0000, 0, 4'b0001, 0, 0, 4'b0001);
    add(1, 0, 1, 4'b0000, 0, 4'b0001, 0, 0, 4'b0001);
    add(1, 0, 1, 4'b0000, 0, 4'b0001, 0, 0, 4'b0001);
    add(1, 1, 1, 4'b0001, 0, 4'b0001, 1, 0, 4'b0001);
    add(1, 0, 1, 4'b0010, 0, 4'b0001, 1, 0, 4'b0011);
    add(1, 0, 0, 4'b0100, 0, 4'b0001, 1, 0, 4'b0011);
    add(1, 0, 0, 4'b1000, 1, 4'b0011, 1, 0, 4'b0011);
    add(1, 1, 0, 4'b0001, 0, 4'b0011, 1, 0, 4'b0010);
    add(1, 0, 0, 4'b0010, 0, 4'b0011, 1, 0, 4'b0000);
    add(1, 1, 1, 4'b0001, 0, 4'b0011, 1, 1, 4'b0001);
    add(1, 0, 0, 4'b0010, 0, 4'b0011, 1, 0, 4'b0001);
    add(1, 0, 0, 4'b0100, 0, 4'b0011, 1, 0, 4'b0001);
    add(1, 0, 1, 4'b1000, 1, 4'b1001, 1, 0, 4'b1001);
    add(1, 1, 1, 4'b0001, 0, 4'b1001, 1, 0, 4'b1001);
    add(1, 0, 1, 4'b0010, 0, 4'b1001, 1, 0, 4'b1011);
    add(0, 1, 0, 4'b0000, 0, 4'b1001, 1, 0, 4'b1011);
    add(0, 1, 0, 4'b0000, 0, 4'b1001, 1, 0, 4'b1011);
    add(0, 1, 0, 4'b0000, 0, 4'b1001, 1, 0, 4'b1011);
    add(1, 0, 1, 4'b0100, 0, 4'b1001, 1, 0, 4'b1111);
    add(1, 0, 1, 4'b1000, 1, 4'b1111, 1, 0, 4'b1111);
    add(0, 0, 0, 4'b0000, 0, 4'b1111, 1, 0, 4'b1111);

    #23;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].fs, tbl[i].d);
      chk($sformatf("vec%0d_strobe", i), 32'(ch_strobe),   32'(tbl[i].stb));
      chk($sformatf("vec%0d_fvalid", i), 32'(frame_valid), 32'(tbl[i].fv));
      chk($sformatf("vec%0d_fdata", i),  32'(frame_data),  32'(tbl[i].fd));
      chk($sformatf("vec%0d_locked", i), 32'(locked),      32'(tbl[i].lk));
      chk($sformatf("vec%0d_syncerr", i),32'(sync_err),    32'(tbl[i].err));
      chk($sformatf("vec%0d_chdata", i), 32'(ch_data),     32'(tbl[i].chd));
    end

    // Asynchronous reset in the middle of a frame, then a clean frame.
    do_reset();
    drive(1, 1, 1'b1);
    drive(1, 0, 1'b1);
    drive(1, 0, 1'b1);
    chk("pre_rst_strobe", 32'(ch_strobe), 32'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 1'b0);
    chk("post_rst_locked", 32'(locked), 32'd1);
    drive(1, 0, 1'b0);
    drive(1, 0, 1'b1);
    chk("post_rst_no_fv", 32'(frame_valid), 32'd0);
    drive(1, 0, 1'b1);
    chk("post_rst_fvalid", 32'(frame_valid), 32'd1);
    chk("post_rst_fdata",  32'(frame_data),  32'b1100);
    drive(0, 0, 1'b0);
    chk("post_rst_fv_pulse", 32'(frame_valid), 32'd0);

    // Randomized traffic with mostly-correct framing and injected sync faults.
    do_reset();
    m_reset();
    gen_slot = 0;
    for (int n = 0; n < 4000; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      fs = 1'b0;
      d  = W'($urandom);
      if (v) begin
        if (gen_slot == 0) fs = ($urandom_range(0, 9) != 0);
        else               fs = ($urandom_range(0, 29) == 0);
        gen_slot = (gen_slot + 1) % 4;
      end else begin
        fs = W'($urandom) != 0;
      end
      drive(v, fs, d);
      m_step(v, fs, d);
      chk("rnd_strobe",  32'(ch_strobe),   32'(m_stb));
      chk("rnd_fvalid",  32'(frame_valid), 32'(m_fv));
      chk("rnd_fdata",   32'(frame_data),  32'(m_fd));
      chk("rnd_locked",  32'(locked),      32'(m_lock));
      chk("rnd_syncerr", 32'(sync_err),    32'(m_err));
      chk("rnd_chdata",  32'(ch_data),     32'(m_chd));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
